// File: rtl/rv_pkg.sv
// rv_pkg: shared definitions for the RISC-V front end.
//   XLEN             - architectural register / address width
//   INSTR_NOP        - canonical NOP encoding (addi x0, x0, 0)
//   RESET_PC_DEFAULT - default PC loaded on reset
//   fetch_pkt_t      - {pc, instr} pair carried from fetch to decode
package rv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] INSTR_NOP        = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_pkt_t;

endpackage : rv_pkg

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetch packets between the PC/memory side
// and decode.
//   clk     - system clock, rising edge
//   rst_n   - asynchronous active-low reset
//   i_push  - write i_data at the tail this cycle
//   i_pop   - retire the head entry this cycle
//   i_flush - drop every entry and rewind both pointers (wins over push/pop)
//   i_data  - packet to write
//   o_count - number of valid entries (0..DEPTH)
//   o_head  - head entry; when empty it repeats the last head shown
//
// The caller must never push into a full FIFO unless it pops in the same
// cycle, and must never pop an empty FIFO.
module fetch_fifo
  import rv_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_flush,
  input  fetch_pkt_t    i_data,
  output logic [CW-1:0] o_count,
  output fetch_pkt_t    o_head
);

  fetch_pkt_t    r_mem [DEPTH];
  fetch_pkt_t    r_last;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic          w_empty;
  fetch_pkt_t    w_rd_data;

  assign w_empty   = (r_count == '0);
  assign w_rd_data = r_mem[r_rd_ptr];

  // Storage needs no reset: nothing reads it while the count is zero.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Shadow of the most recently shown head, so the outputs hold their last
  // values once the FIFO drains or is flushed instead of exposing stale slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= '0;
    end else if (!w_empty) begin
      r_last <= w_rd_data;
    end
  end

  assign o_count = r_count;
  assign o_head  = w_empty ? r_last : w_rd_data;

endmodule : fetch_fifo

// File: rtl/instr_fetch.sv
// instr_fetch: front-end fetch unit. Owns the PC, drives the word-addressed
// instruction memory read port, buffers {pc, instr} pairs and hands them to
// decode.
//   clk         - system clock, rising edge
//   rst_n       - asynchronous active-low reset
//   a_instr     - fetch address to instruction memory (the PC register)
//   rd_instr    - instruction returned combinationally for a_instr
//   halt        - stop issuing fetches; buffered entries keep draining
//   redirect    - flush the buffer and reload the PC from redirect_pc
//   redirect_pc - new PC; the low two bits are cleared on load
//   out_valid   - buffer head holds a valid instruction
//   out_ready   - decode accepts the head this cycle
//   out_instr   - instruction at the buffer head
//   out_pc      - PC of out_instr
//   out_pc4     - out_pc + 4
//
// Handshake: an entry transfers on every rising edge where out_valid and
// out_ready are both 1. out_valid never falls without a transfer or a
// redirect, and out_* stay stable while out_valid=1 and out_ready=0. A
// transfer in the same cycle as a redirect still counts: decode owns it.
module instr_fetch
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned DEPTH    = 2,
  localparam int unsigned CW      = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] a_instr,
  input  logic [31:0] rd_instr,
  input  logic        halt,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc4
);

  logic [31:0]   r_pc;
  logic [CW-1:0] w_count;
  fetch_pkt_t    w_head;
  fetch_pkt_t    w_push_pkt;
  logic          w_full;
  logic          w_pop;
  logic          w_fetch;
  logic [31:0]   w_target;

  assign w_full   = (w_count == CW'(DEPTH));
  assign w_pop    = out_valid & out_ready;
  // A full buffer that pops this cycle frees the slot the push lands in.
  assign w_fetch  = !redirect && !halt && (!w_full || w_pop);
  assign w_target = redirect_pc & 32'hFFFF_FFFC;

  assign w_push_pkt.pc    = r_pc;
  assign w_push_pkt.instr = rd_instr;

  // Redirect outranks halt and fetch; halt only blocks the PC advance, so a
  // redirect during halt still reloads the PC for when fetch resumes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (redirect) begin
      r_pc <= w_target;
    end else if (w_fetch) begin
      r_pc <= r_pc + 32'd4;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_fetch),
    .i_pop   (w_pop),
    .i_flush (redirect),
    .i_data  (w_push_pkt),
    .o_count (w_count),
    .o_head  (w_head)
  );

  assign a_instr   = r_pc;
  assign out_valid = (w_count != '0);
  assign out_instr = w_head.instr;
  assign out_pc    = w_head.pc;
  assign out_pc4   = w_head.pc + 32'd4;

endmodule : instr_fetch

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic [31:0] a_instr;
  logic [31:0] rd_instr;
  logic        halt;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc4;

  // second instance exercising PC wrap
  logic [31:0] a_instr_w;
  logic [31:0] rd_instr_w;
  logic        out_valid_w;
  logic [31:0] out_instr_w;
  logic [31:0] out_pc_w;
  logic [31:0] out_pc4_w;

  int n_total;
  int n_bad;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- instruction memory model ----------------
  function automatic logic [31:0] imem(input logic [31:0] a);
    case (a[31:2])
      30'd0:   return 32'h0050_0093;
      30'd1:   return 32'h00A0_0113;
      30'd2:   return 32'h0020_81B3;
      30'd3:   return 32'h0000_006F;
      default: return {16'hC0DE, a[15:0]};
    endcase
  endfunction

  assign rd_instr   = imem(a_instr);
  assign rd_instr_w = imem(a_instr_w);

  instr_fetch u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .a_instr     (a_instr),
    .rd_instr    (rd_instr),
    .halt        (halt),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .out_pc4     (out_pc4)
  );

  instr_fetch #(
    .RESET_PC (32'hFFFF_FFF8)
  ) u_wrap (
    .clk         (clk),
    .rst_n       (rst_n),
    .a_instr     (a_instr_w),
    .rd_instr    (rd_instr_w),
    .halt        (1'b0),
    .redirect    (1'b0),
    .redirect_pc (32'h0),
    .out_valid   (out_valid_w),
    .out_ready   (1'b1),
    .out_instr   (out_instr_w),
    .out_pc      (out_pc_w),
    .out_pc4     (out_pc4_w)
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Assert reset away from an edge, hold for two edges, release away from an edge.
  task automatic do_reset(input logic ready);
    rst_n       = 1'b0;
    halt        = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    out_ready   = ready;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Check the head of the stream against a pc, with instr/pc4 from the model.
  task automatic check_head(input string name, input logic [31:0] exp_pc);
    n_total++;
    if (out_valid !== 1'b1 || out_pc !== exp_pc || out_instr !== imem(exp_pc) ||
        out_pc4 !== exp_pc + 32'd4) begin
      n_bad++;
      $display("FAIL %s: valid=%0b pc=%h instr=%h pc4=%h, expected valid=1 pc=%h instr=%h pc4=%h",
               name, out_valid, out_pc, out_instr, out_pc4, exp_pc, imem(exp_pc), exp_pc + 32'd4);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; halt = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; out_ready = 1'b1;
    #3;
    n_total++;
    if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'h0 ||
        out_pc4 !== 32'h4 || a_instr !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_state: valid=%0b pc=%h instr=%h pc4=%h a=%h, expected 0/0/0/4/0",
               out_valid, out_pc, out_instr, out_pc4, a_instr);
    end
    step();
    rst_n = 1'b1;
    n_total++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release_valid: got %0b expected 0", out_valid);
    end
  endtask

  task automatic test_stream();
    logic [31:0] exp_q[$];
    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
    do_reset(1'b1);
    foreach (exp_q[i]) begin
      step();
      check_head("stream", exp_q[i]);
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp_q[$];
    do_reset(1'b0);
    step();  // first fetch of pc 0
    check_head("stall_first", 32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      check_head("stall_hold", 32'h0);
      n_total++;
      if (a_instr !== 32'h8) begin
        n_bad++;
        $display("FAIL stall_addr: a_instr=%h expected 00000008", a_instr);
      end
    end
    out_ready = 1'b1;
    exp_q = '{32'h4, 32'h8, 32'hC};
    foreach (exp_q[i]) begin
      step();
      check_head("stall_release", exp_q[i]);
    end
  endtask

  task automatic test_redirect();
    do_reset(1'b0);
    step();
    step();  // two entries buffered, a_instr=8
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0042;
    step();
    redirect  = 1'b0;
    out_ready = 1'b1;
    n_total++;
    if (out_valid !== 1'b0 || a_instr !== 32'h40) begin
      n_bad++;
      $display("FAIL redirect_t1: valid=%0b a=%h expected valid=0 a=00000040", out_valid, a_instr);
    end
    step();
    check_head("redirect_t2", 32'h40);
    step();
    check_head("redirect_t3", 32'h44);
    // back-to-back redirects: last one wins
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0100;
    step();
    redirect_pc = 32'h0000_0203;
    step();
    redirect = 1'b0;
    n_total++;
    if (out_valid !== 1'b0 || a_instr !== 32'h200) begin
      n_bad++;
      $display("FAIL redirect_b2b: valid=%0b a=%h expected valid=0 a=00000200", out_valid, a_instr);
    end
    step();
    check_head("redirect_b2b_first", 32'h200);
  endtask

  task automatic test_halt();
    do_reset(1'b1);
    step();
    step();  // head pc 4, a_instr 8
    halt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_total++;
      if (out_valid !== 1'b0 || a_instr !== 32'h8 || out_pc !== 32'h4) begin
        n_bad++;
        $display("FAIL halt_drain: valid=%0b a=%h pc=%h expected valid=0 a=00000008 pc=00000004",
                 out_valid, a_instr, out_pc);
      end
    end
    halt = 1'b0;
    step();
    check_head("halt_resume", 32'h8);
    step();
    check_head("halt_resume_next", 32'hC);
    // redirect while halted reloads the pc; fetch starts there after halt drops
    halt        = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0080;
    step();
    redirect = 1'b0;
    step();
    n_total++;
    if (out_valid !== 1'b0 || a_instr !== 32'h80) begin
      n_bad++;
      $display("FAIL halt_redirect: valid=%0b a=%h expected valid=0 a=00000080", out_valid, a_instr);
    end
    halt = 1'b0;
    step();
    check_head("halt_redirect_resume", 32'h80);
  endtask

  task automatic test_async_reset();
    do_reset(1'b0);
    step();
    step();  // buffer full
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (out_valid !== 1'b0 || a_instr !== 32'h0) begin
      n_bad++;
      $display("FAIL async_reset: valid=%0b a=%h expected valid=0 a=00000000", out_valid, a_instr);
    end
    step();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    step();
    check_head("async_restart0", 32'h0);
    step();
    check_head("async_restart1", 32'h4);
  endtask

  task automatic test_pc_wrap();
    logic [31:0] exp_q[$];
    exp_q = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    do_reset(1'b1);
    foreach (exp_q[i]) begin
      step();
      n_total++;
      if (out_valid_w !== 1'b1 || out_pc_w !== exp_q[i] || out_instr_w !== imem(exp_q[i]) ||
          out_pc4_w !== exp_q[i] + 32'd4) begin
        n_bad++;
        $display("FAIL pc_wrap: valid=%0b pc=%h instr=%h pc4=%h, expected pc=%h instr=%h pc4=%h",
                 out_valid_w, out_pc_w, out_instr_w, out_pc4_w, exp_q[i], imem(exp_q[i]),
                 exp_q[i] + 32'd4);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    n_total = 0;
    n_bad   = 0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_halt();
    test_async_reset();
    test_pc_wrap();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_instr_fetch

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Front-end fetch unit of the RISC-V core, and the initiator side of the instruction memory's word-addressed read port.
- Holds the PC and drives the fetch address.
- Captures the combinationally returned instruction word into a small FIFO.
- Hands {pc, instr} to decode over a valid/ready handshake; supports branch/jump redirect with flush, plus halt.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.
- DEPTH, 2, fetch buffer entries (power of two, >=2).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a_instr  output  32  fetch address to instruction memory; equals PC register.
- rd_instr  input  32  instruction word returned combinationally for a_instr, same cycle.
- halt  input  1  when 1, no new fetch is issued; buffered entries still drain.
- redirect  input  1  taken branch/jump/exception: flush and reload PC.
- redirect_pc  input  32  new PC; bits [1:0] forced to 0 on load.
- out_valid  output  1  buffer head holds a valid instruction.
- out_ready  input  1  decode accepts head this cycle.
- out_instr  output  32  instruction at buffer head.
- out_pc  output  32  PC of out_instr.
- out_pc4  output  32  out_pc + 4.

Behaviour:
- Reset (async assert, sync release): pc=RESET_PC, count=0, rd/wr pointers=0, out_valid=0.
  - Reset also clears out_instr=0, out_pc=0, out_pc4=4.
  - Reset mid-operation discards all buffered entries immediately.
- pop = out_valid & out_ready.
- fetch = !redirect & !halt & (count<DEPTH | pop). A full buffer with a same-cycle pop still fetches.
- Fetch cycle:
  - Push {pc, rd_instr} at the write pointer.
  - pc <= pc + 4, mod 2^32, wrapping 32'hFFFF_FFFC -> 0.
  - Memory index wrap beyond its word depth belongs to the memory, not this block.
- Count update: count <= count + fetch - pop. Pointers wrap mod DEPTH.
- Latency: the instruction fetched at cycle T appears on out_* at T+1 if the buffer was empty.
  - Peak throughput: 1 instr/cycle with out_ready held high.
- Outputs come from the buffer head register/array read, not combinational from rd_instr. out_valid = (count != 0).
- Redirect at cycle T (priority over halt and fetch):
  - count<=0 and pointers<=0. All buffered entries are dropped.
  - pc <= {redirect_pc[31:2],2'b00}. No push at T.
  - A pop at T is still a completed handshake; decode owns that entry.
  - T+1: out_valid=0; a_instr = target.
  - T+2: first target instruction valid (absent halt).
- Redirect while halt=1: PC reloads; fetch resumes from the target when halt drops.
- Back-to-back redirects: the last one wins; no intermediate fetches escape.
- Empty buffer with out_ready=1: no pop; out_* hold their last values, and consumers must not use them when out_valid=0.
- out_valid never drops without a pop or redirect. out_instr/out_pc are stable while out_valid=1 & out_ready=0.

Decomposition:
- Shared package rv_pkg holds:
  - XLEN=32;
  - INSTR_NOP=32'h0000_0013;
  - RESET_PC default;
  - typedef fetch_pkt_t {pc[31:0], instr[31:0]}.
- One sub-module, fetch_fifo: synchronous FIFO of fetch_pkt_t, DEPTH entries.
  - Inputs: push, pop, flush.
  - Outputs: count, head.
  - Same clk/rst_n.
- instr_fetch contains the PC register, fetch/redirect control and the memory interface.

Test Plan:
- Reset, memory words 0..3 = 0x00500093, 0x00A00113, 0x002081B3, 0x0000006F; out_ready=1 -> out_valid rises 1 cycle after reset release, out_pc=0,4,8,C on consecutive cycles with matching instr, out_pc4=4,8,C,10.
- out_ready=0 for 5 cycles after first fetch -> count saturates at 2, a_instr holds 0x8, out_pc stays 0. Raise out_ready -> pcs 0,4,8 delivered back-to-back with no gap or duplicate.
- Redirect at cycle T, redirect_pc=0x0000_0042, with 2 entries buffered:
  - T+1: out_valid=0 and a_instr=0x40.
  - T+2: out_pc=0x40.
  - No old-path entry appears after T.
- halt=1 for 3 cycles with out_ready=1 -> buffer drains to empty, a_instr frozen; halt=0 -> fetch resumes at the frozen PC with no skipped address.
- rst_n asserted mid-stream with buffer full -> out_valid=0 asynchronously and a_instr=RESET_PC before the next edge; after release, stream restarts at pc 0.
- PC wrap with RESET_PC=0xFFFF_FFF8 -> out_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
